throw_controller: RTL and testbench

THROW_CONTROLLER -- requirements
Module: throw_controller

---
 rtl/throw_controller.sv | 200 ++++++++++++++++++++
 tb/tb_throw_controller.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/throw_controller.sv
// Throw controller: aims and charges a throw, launches it to the ball engine, waits for the
// roll to finish or time out, then cools down before the next throw until the game ends.
module throw_controller #(
  parameter int MIN_SPEED      = 1,
  parameter int MAX_SPEED      = 16,
  parameter int MAX_AIM        = 8,
  parameter int CHARGE_DIV     = 4,
  parameter int ROLL_TIMEOUT   = 600,
  parameter int COOLDOWN_TICKS = 60,
  parameter int MAX_THROWS     = 10
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        tick_in,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        btn_throw,
  input  logic        ball_done,
  output logic        valid_out,
  output logic [15:0] speed_x_out,
  output logic [15:0] speed_y_out,
  output logic        vy_neg_out,
  output logic [2:0]  state_out,
  output logic [3:0]  throw_count,
  output logic        game_over,
  output logic        timeout_flag
);

  localparam int AW = $clog2(MAX_AIM + 1) + 1;
  localparam int DW = $clog2(CHARGE_DIV + 1);
  localparam int RW = $clog2(ROLL_TIMEOUT + 1);
  localparam int CW = $clog2(COOLDOWN_TICKS + 1);

  localparam logic signed [AW-1:0] AIM_HI     = AW'(MAX_AIM);
  localparam logic signed [AW-1:0] AIM_LO     = -AIM_HI;
  localparam logic signed [AW-1:0] AIM_ONE    = AW'(1);
  localparam logic        [15:0]   SPEED_MIN  = 16'(MIN_SPEED);
  localparam logic        [15:0]   SPEED_MAX  = 16'(MAX_SPEED);
  localparam logic        [DW-1:0] DIV_LAST   = DW'(CHARGE_DIV - 1);
  localparam logic        [RW-1:0] ROLL_LAST  = RW'(ROLL_TIMEOUT - 1);
  localparam logic        [CW-1:0] COOL_LAST  = CW'(COOLDOWN_TICKS - 1);
  localparam logic        [3:0]    THROWS_MAX = 4'(MAX_THROWS);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_AIM      = 3'd1,
    S_CHARGE   = 3'd2,
    S_LAUNCH   = 3'd3,
    S_ROLLING  = 3'd4,
    S_COOLDOWN = 3'd5
  } state_e;

  state_e                 state_q, state_d;
  logic signed [AW-1:0]   aim_q, aim_d;
  logic        [15:0]     charge_q, charge_d;
  logic        [DW-1:0]   div_q, div_d;
  logic        [RW-1:0]   roll_q, roll_d;
  logic        [CW-1:0]   cool_q, cool_d;
  logic        [15:0]     speed_x_q, speed_x_d;
  logic        [15:0]     speed_y_q, speed_y_d;
  logic                   vy_neg_q, vy_neg_d;
  logic        [3:0]      count_q, count_d;
  logic                   timeout_q, timeout_d;
  logic                   throw_prev_q, throw_prev_d;
  logic                   done_prev_q, done_prev_d;

  logic          throw_rise, throw_fall, done_rise, roll_end;
  logic [AW-1:0] aim_mag;

  assign throw_rise = btn_throw & ~throw_prev_q;
  assign throw_fall = ~btn_throw & throw_prev_q;
  assign done_rise  = ball_done & ~done_prev_q;

  // NOTE: every variable gets its default first so no path through the case infers a latch.
  always_comb begin
    state_d      = state_q;
    aim_d        = aim_q;
    charge_d     = charge_q;
    div_d        = div_q;
    roll_d       = roll_q;
    cool_d       = cool_q;
    speed_x_d    = speed_x_q;
    speed_y_d    = speed_y_q;
    vy_neg_d     = vy_neg_q;
    count_d      = count_q;
    timeout_d    = timeout_q;
    throw_prev_d = btn_throw;
    done_prev_d  = ball_done;
    roll_end     = 1'b0;
    aim_mag      = aim_q[AW-1] ? unsigned'(-aim_q) : unsigned'(aim_q);

    case (state_q)
      S_IDLE: begin
        if (!game_over && !btn_throw) state_d = S_AIM;
      end
      S_AIM: begin
        // A throw press takes priority; its tick never moves the aim.
        if (throw_rise) begin
          state_d  = S_CHARGE;
          charge_d = SPEED_MIN;
          div_d    = '0;
        end else if (tick_in && (btn_left ^ btn_right)) begin
          if (btn_right && aim_q != AIM_HI) aim_d = aim_q + AIM_ONE;
          if (btn_left  && aim_q != AIM_LO) aim_d = aim_q - AIM_ONE;
        end
      end
      S_CHARGE: begin
        if (throw_fall) begin
          state_d   = S_LAUNCH;
          speed_x_d = charge_q;
          speed_y_d = 16'(aim_mag);
          vy_neg_d  = aim_q[AW-1];
        end else if (tick_in) begin
          if (div_q == DIV_LAST) begin
            div_d = '0;
            if (charge_q < SPEED_MAX) charge_d = charge_q + 16'd1;
          end else begin
            div_d = div_q + DW'(1);
          end
        end
      end
      S_LAUNCH: begin
        state_d = S_ROLLING;
        roll_d  = '0;
      end
      S_ROLLING: begin
        if (done_rise) begin
          roll_end = 1'b1;
        end else if (tick_in) begin
          if (roll_q == ROLL_LAST) begin
            roll_end  = 1'b1;
            timeout_d = 1'b1;
          end else begin
            roll_d = roll_q + RW'(1);
          end
        end
      end
      S_COOLDOWN: begin
        if (tick_in) begin
          if (cool_q == COOL_LAST) begin
            state_d = S_IDLE;
            aim_d   = '0;
          end else begin
            cool_d = cool_q + CW'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (roll_end) begin
      state_d = S_COOLDOWN;
      cool_d  = '0;
      if (count_q != THROWS_MAX) count_d = count_q + 4'd1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q      <= S_IDLE;
      aim_q        <= '0;
      charge_q     <= '0;
      div_q        <= '0;
      roll_q       <= '0;
      cool_q       <= '0;
      speed_x_q    <= '0;
      speed_y_q    <= '0;
      vy_neg_q     <= 1'b0;
      count_q      <= '0;
      timeout_q    <= 1'b0;
      throw_prev_q <= 1'b0;
      done_prev_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      aim_q        <= aim_d;
      charge_q     <= charge_d;
      div_q        <= div_d;
      roll_q       <= roll_d;
      cool_q       <= cool_d;
      speed_x_q    <= speed_x_d;
      speed_y_q    <= speed_y_d;
      vy_neg_q     <= vy_neg_d;
      count_q      <= count_d;
      timeout_q    <= timeout_d;
      throw_prev_q <= throw_prev_d;
      done_prev_q  <= done_prev_d;
    end
  end

  assign valid_out    = (state_q == S_LAUNCH) || (state_q == S_ROLLING);
  assign speed_x_out  = speed_x_q;
  assign speed_y_out  = speed_y_q;
  assign vy_neg_out   = vy_neg_q;
  assign state_out    = state_q;
  assign throw_count  = count_q;
  assign game_over    = (count_q == THROWS_MAX);
  assign timeout_flag = timeout_q;

endmodule

// File: tb/tb_throw_controller.sv
// Bench for throw_controller: an integer-level game model checked every cycle, plus
// directed throws with hand-computed launch values, timeout, reset and game-over cases.
module tb_throw_controller;

  localparam int MIN_SPEED      = 1;
  localparam int MAX_SPEED      = 16;
  localparam int MAX_AIM        = 8;
  localparam int CHARGE_DIV     = 4;
  localparam int ROLL_TIMEOUT   = 600;
  localparam int COOLDOWN_TICKS = 60;
  localparam int MAX_THROWS     = 10;

  logic        clk = 1'b0;
  logic        rst, tick, left, right, throw_btn, done;
  logic        valid_out, vy_neg_out, game_over, timeout_flag;
  logic [15:0] speed_x_out, speed_y_out;
  logic [2:0]  state_out;
  logic [3:0]  throw_count;

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 1'b0;

  throw_controller #(
    .MIN_SPEED(MIN_SPEED), .MAX_SPEED(MAX_SPEED), .MAX_AIM(MAX_AIM),
    .CHARGE_DIV(CHARGE_DIV), .ROLL_TIMEOUT(ROLL_TIMEOUT),
    .COOLDOWN_TICKS(COOLDOWN_TICKS), .MAX_THROWS(MAX_THROWS)
  ) dut (
    .clk_in(clk), .rst_in(rst), .tick_in(tick), .btn_left(left), .btn_right(right),
    .btn_throw(throw_btn), .ball_done(done), .valid_out(valid_out),
    .speed_x_out(speed_x_out), .speed_y_out(speed_y_out), .vy_neg_out(vy_neg_out),
    .state_out(state_out), .throw_count(throw_count), .game_over(game_over),
    .timeout_flag(timeout_flag)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Game model: plain integers, charge derived from total ticks held.
  int m_state = 0, m_aim = 0, m_ticks = 0, m_roll = 0, m_cool = 0, m_count = 0;
  int m_vx = 0, m_vy = 0;
  bit m_neg = 0, m_tflag = 0, m_prev_throw = 0, m_prev_done = 0;

  function automatic int charge_of(input int n);
    int c;
    c = MIN_SPEED + n / CHARGE_DIV;
    return (c > MAX_SPEED) ? MAX_SPEED : c;
  endfunction

  task automatic model_finish_roll();
    m_state = 5;
    m_cool  = 0;
    if (m_count < MAX_THROWS) m_count++;
  endtask

  task automatic model_step();
    bit trise, tfall, drise;
    trise = throw_btn && !m_prev_throw;
    tfall = !throw_btn && m_prev_throw;
    drise = done && !m_prev_done;
    if (rst) begin
      m_state = 0; m_aim = 0; m_ticks = 0; m_roll = 0; m_cool = 0; m_count = 0;
      m_vx = 0; m_vy = 0; m_neg = 0; m_tflag = 0;
    end else begin
      case (m_state)
        0: if (m_count != MAX_THROWS && !throw_btn) m_state = 1;
        1: if (trise) begin
             m_state = 2; m_ticks = 0;
           end else if (tick && (left != right)) begin
             m_aim = m_aim + (right ? 1 : -1);
             if (m_aim > MAX_AIM)  m_aim = MAX_AIM;
             if (m_aim < -MAX_AIM) m_aim = -MAX_AIM;
           end
        2: if (tfall) begin
             m_state = 3;
             m_vx  = charge_of(m_ticks);
             m_vy  = (m_aim < 0) ? -m_aim : m_aim;
             m_neg = (m_aim < 0);
           end else if (tick) m_ticks++;
        3: begin m_state = 4; m_roll = 0; end
        4: if (drise) model_finish_roll();
           else if (tick) begin
             m_roll++;
             if (m_roll == ROLL_TIMEOUT) begin m_tflag = 1; model_finish_roll(); end
           end
        5: if (tick) begin
             m_cool++;
             if (m_cool == COOLDOWN_TICKS) begin m_state = 0; m_aim = 0; end
           end
        default: m_state = 0;
      endcase
    end
    m_prev_throw = rst ? 1'b0 : throw_btn;
    m_prev_done  = rst ? 1'b0 : done;
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (cmp_en) begin
      check("state",     32'(state_out),    m_state);
      check("valid",     32'(valid_out),    32'((m_state == 3) || (m_state == 4)));
      check("speed_x",   32'(speed_x_out),  m_vx);
      check("speed_y",   32'(speed_y_out),  m_vy);
      check("vy_neg",    32'(vy_neg_out),   32'(m_neg));
      check("count",     32'(throw_count),  m_count);
      check("game_over", 32'(game_over),    32'(m_count == MAX_THROWS));
      check("timeout",   32'(timeout_flag), 32'(m_tflag));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got 0, expected 1");
    $fatal(1);
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic tick_n(input int n);
    repeat (n) begin
      tick = 1'b1; cyc(1);
      tick = 1'b0; cyc(1);
    end
  endtask

  task automatic wait_state(input int s, input int budget);
    int k;
    k = 0;
    while (state_out !== 3'(s) && k < budget) begin cyc(1); k++; end
    check("wait_state", 32'(state_out), s);
  endtask

  task automatic simple_throw_done();
    wait_state(1, 10);
    throw_btn = 1'b1; cyc(1);
    throw_btn = 1'b0; cyc(2);
    done = 1'b1; cyc(1);
    done = 1'b0;
    tick_n(COOLDOWN_TICKS);
  endtask

  initial begin
    rst = 1'b1; tick = 1'b0; left = 1'b0; right = 1'b0; throw_btn = 1'b0; done = 1'b0;
    cyc(2);
    cmp_en = 1'b1;
    check("rst_state", 32'(state_out), 0);
    check("rst_valid", 32'(valid_out), 0);
    check("rst_speed_x", 32'(speed_x_out), 0);
    check("rst_count", 32'(throw_count), 0);
    rst = 1'b0;
    cyc(1);
    check("idle_to_aim", 32'(state_out), 1);

    // Throw A: aim +3, 9 charge ticks -> speed_x 3; rise-cycle tick must not move aim.
    right = 1'b1; tick_n(3);
    throw_btn = 1'b1; tick = 1'b1; cyc(1);
    tick = 1'b0; right = 1'b0;
    check("a_charge", 32'(state_out), 2);
    tick_n(9);
    throw_btn = 1'b0;
    check("a_valid_before", 32'(valid_out), 0);
    cyc(1);
    check("a_valid_rise", 32'(valid_out), 1);
    check("a_speed_x", 32'(speed_x_out), 3);
    check("a_speed_y", 32'(speed_y_out), 3);
    check("a_vy_neg", 32'(vy_neg_out), 0);
    cyc(1);
    // Buttons during the roll are ignored; then done rise ties with the final timeout tick.
    left = 1'b1; tick_n(ROLL_TIMEOUT - 1); left = 1'b0;
    tick = 1'b1; done = 1'b1; cyc(1);
    tick = 1'b0; done = 1'b0;
    check("a_tie_state", 32'(state_out), 5);
    check("a_tie_timeout", 32'(timeout_flag), 0);
    check("a_count", 32'(throw_count), 1);
    tick_n(COOLDOWN_TICKS);

    // Throw B: aim saturates at -8; fall-cycle tick is ignored (3 ticks -> speed 1).
    wait_state(1, 10);
    left = 1'b1; tick_n(12);
    right = 1'b1; tick_n(2);
    left = 1'b0; right = 1'b0;
    throw_btn = 1'b1; cyc(1);
    tick_n(3);
    throw_btn = 1'b0; tick = 1'b1; cyc(1);
    tick = 1'b0;
    check("b_speed_x", 32'(speed_x_out), 1);
    check("b_speed_y", 32'(speed_y_out), 8);
    check("b_vy_neg", 32'(vy_neg_out), 1);
    cyc(1);
    check("b_rolling", 32'(state_out), 4);
    // Reset mid-roll overrides a simultaneous done rise and tick.
    rst = 1'b1; done = 1'b1; tick = 1'b1; cyc(1);
    rst = 1'b0; done = 1'b0; tick = 1'b0;
    check("r_state", 32'(state_out), 0);
    check("r_valid", 32'(valid_out), 0);
    check("r_speed_y", 32'(speed_y_out), 0);
    check("r_vy_neg", 32'(vy_neg_out), 0);
    check("r_count", 32'(throw_count), 0);

    // Throw C: 100 charge ticks saturate at 16; roll ends by timeout.
    wait_state(1, 10);
    throw_btn = 1'b1; cyc(1);
    tick_n(100);
    throw_btn = 1'b0; cyc(1);
    check("c_speed_x", 32'(speed_x_out), 16);
    check("c_speed_y", 32'(speed_y_out), 0);
    cyc(1);
    tick_n(ROLL_TIMEOUT);
    check("c_valid", 32'(valid_out), 0);
    check("c_timeout", 32'(timeout_flag), 1);
    check("c_count", 32'(throw_count), 1);
    check("c_cooldown", 32'(state_out), 5);
    tick_n(COOLDOWN_TICKS);

    // Nine more throws reach game over; the throw button then does nothing.
    for (int i = 0; i < MAX_THROWS - 1; i++) simple_throw_done();
    check("g_count", 32'(throw_count), 10);
    check("g_game_over", 32'(game_over), 1);
    throw_btn = 1'b1; tick_n(3);
    throw_btn = 1'b0; cyc(3);
    check("g_idle", 32'(state_out), 0);
    check("g_valid", 32'(valid_out), 0);
    check("g_timeout_sticky", 32'(timeout_flag), 1);

    cmp_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
